// File: rtl/notch_pkg.sv
// notch_pkg: shared FSM encodings and width defaults for the notch_* blocks
package notch_pkg;
  localparam int NOTCH_DATA_SIZE = 24;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
endpackage

// File: rtl/notch_out_capture_if.sv
// notch_out_capture_if: captured-sample valid/ready stream
//   m_data  head-of-FIFO sample, 0 while m_valid is low
//   m_valid FIFO not empty
//   m_ready consumer accepts m_data this cycle
interface notch_out_capture_if
  import notch_pkg::*;
#(
  parameter int DATA_SIZE = NOTCH_DATA_SIZE
);
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  modport master(output m_data, m_valid, input m_ready);
  modport slave(input m_data, m_valid, output m_ready);
endinterface

// File: rtl/notch_sync_fifo.sv
// notch_sync_fifo: first-word-fall-through FIFO with registered head and occupancy
//   clk, reset   clock, synchronous active-low reset
//   wr, wdata    write request; accepted when accept is high
//   accept       room available, counting a pop in the same cycle
//   rdata/rvalid registered head word (0 when empty) and not-empty flag
//   rready       pop request, ignored when empty
//   count        occupancy 0..2**ADDR_SIZE
module notch_sync_fifo #(
  parameter int DATA_SIZE = 24,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic                 accept,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [ADDR_SIZE:0]   count
);
  localparam int DEPTH = 1 << ADDR_SIZE;
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wptr, rptr, rptr_n;
  logic [ADDR_SIZE:0]   left;
  logic                 pop, push;
  assign pop    = rvalid & rready;
  // count's MSB alone marks full since count never exceeds DEPTH
  assign accept = ~count[ADDR_SIZE] | pop;
  assign push   = wr & accept;
  assign rptr_n = rptr + ADDR_SIZE'(pop);
  // entries still held after this cycle's pop, before this cycle's write
  assign left   = count - (ADDR_SIZE+1)'(pop);
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;
  // head is registered: an older entry if any survive the pop, otherwise the word being written
  always_ff @(posedge clk)
    if (!reset) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      wptr   <= wptr + ADDR_SIZE'(push);
      rptr   <= rptr_n;
      count  <= left + (ADDR_SIZE+1)'(push);
      rvalid <= (left != '0) | push;
      rdata  <= (left != '0) ? mem[rptr_n] : push ? wdata : '0;
    end
endmodule

// File: rtl/notch_out_capture.sv
// notch_out_capture: captures notch_top output a fixed settle time after each sample_trig edge
//   clk, reset   clock, synchronous active-low reset
//   sample_trig  sample strobe shared with notch_top
//   data_in      notch_top.data_out
//   m            captured-sample stream (master side)
//   count        FIFO occupancy
//   overflow     sticky, a capture was dropped on a full FIFO
//   trig_missed  sticky, a trigger edge arrived outside IDLE
module notch_out_capture
  import notch_pkg::*;
#(
  parameter int DATA_SIZE     = NOTCH_DATA_SIZE,
  parameter int SETTLE_CYCLES = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int ADDR_SIZE     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_trig,
  input  logic [DATA_SIZE-1:0]   data_in,
  notch_out_capture_if.master    m,
  output logic [ADDR_SIZE:0]     count,
  output logic                   overflow,
  output logic                   trig_missed
);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  logic [1:0] state, state_n;
  logic [7:0] cnt;
  logic       trig_q, trig_edge, capture, accept;
  assign trig_edge = sample_trig & ~trig_q;
  assign capture   = state == CAPTURE;
  always_comb
    state_n = (state == IDLE)   ? (trig_edge ? SETTLE : IDLE) :
              (state == SETTLE) ? (cnt == 8'd0 ? CAPTURE : SETTLE) : IDLE;
  // trig_q resets high so a strobe already high at reset release is not an edge
  always_ff @(posedge clk)
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      trig_q      <= 1'b1;
      overflow    <= 1'b0;
      trig_missed <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= (state == SETTLE) ? cnt - 8'd1 : SETTLE_LOAD;
      trig_q      <= sample_trig;
      overflow    <= overflow | (capture & ~accept);
      trig_missed <= trig_missed | (trig_edge & (state != IDLE));
    end
  notch_sync_fifo #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (capture),
    .wdata  (data_in),
    .accept (accept),
    .rdata  (m.m_data),
    .rvalid (m.m_valid),
    .rready (m.m_ready),
    .count  (count)
  );
endmodule

// File: tb/tb_notch_out_capture.sv
// tb_notch_out_capture: randomized scoreboard bench for notch_out_capture
module tb_notch_out_capture;
  localparam int DS = 24;
  localparam int S  = 16;
  localparam int D  = 16;
  logic          clk = 0;
  logic          reset;
  logic          sample_trig;
  logic [DS-1:0] data_in;
  logic [4:0]    count;
  logic          overflow, trig_missed;
  notch_out_capture_if #(.DATA_SIZE(DS)) m ();
  notch_out_capture #(
    .DATA_SIZE(DS), .SETTLE_CYCLES(S), .FIFO_DEPTH(D), .ADDR_SIZE(4)
  ) dut (
    .clk(clk), .reset(reset), .sample_trig(sample_trig), .data_in(data_in),
    .m(m), .count(count), .overflow(overflow), .trig_missed(trig_missed)
  );
  always #10 clk = ~clk;
  int vectors = 0, miscompares = 0;
  bit run = 0, rnd = 0, tog = 0;
  logic [DS-1:0] sb [$];
  int  mcnt = 0, cyc = 0, cap_at = -1;
  bit  prev = 1, movf = 0, mmiss = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // reference model: a trigger edge is taken only if no capture is pending;
  // its capture happens S+1 clocks later into a 16-deep queue
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      sb.delete();
      mcnt = 0; cap_at = -1; prev = 1; movf = 0; mmiss = 0;
    end else begin
      bit e, busy, pop, push;
      e    = sample_trig & ~prev;
      prev = sample_trig;
      busy = cyc <= cap_at;
      pop  = (mcnt > 0) && m.m_ready;
      push = 0;
      if (cyc == cap_at) begin
        if (mcnt < D || pop) begin sb.push_back(data_in); push = 1; end
        else movf = 1;
      end
      if (e) begin
        if (busy) mmiss = 1;
        else cap_at = cyc + S + 1;
      end
      mcnt = mcnt + int'(push) - int'(pop);
    end
  end
  always @(negedge clk)
    if (run) begin
      chk("m_valid", 32'(m.m_valid), 32'(mcnt != 0));
      chk("count", 32'(count), 32'(mcnt));
      chk("overflow", 32'(overflow), 32'(movf));
      chk("trig_missed", 32'(trig_missed), 32'(mmiss));
      if (!m.m_valid) chk("m_data_idle", 32'(m.m_data), 32'd0);
      else if (sb.size() == 0) chk("sb_empty", 32'(m.m_valid), 32'd0);
      else if (m.m_ready) chk("pop_data", 32'(m.m_data), 32'(sb.pop_front()));
      else chk("head_data", 32'(m.m_data), 32'(sb[0]));
    end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd) data_in = DS'($urandom);
      if (tog) m.m_ready = ~m.m_ready;
    end
  endtask
  task automatic pulse(input logic [DS-1:0] d, input int len);
    sample_trig = 1;
    if (!rnd) data_in = d;
    step(len);
    sample_trig = 0;
  endtask
  task automatic do_reset();
    reset = 0; m.m_ready = 0; sample_trig = 0;
    step(2);
    reset = 1;
  endtask
  initial begin
    reset = 0; sample_trig = 1; data_in = '0; m.m_ready = 0;
    step(2);
    run = 1;
    reset = 1;
    step(3);
    sample_trig = 0;
    step(2);
    pulse(24'h123456, 3);
    step(25);
    m.m_ready = 1; step(1); m.m_ready = 0; step(3);
    do_reset();
    for (int i = 1; i <= 16; i++) begin pulse(DS'(i), 1); step(19); end
    pulse(24'd17, 1); step(20);
    m.m_ready = 1; step(20); m.m_ready = 0;
    do_reset();
    for (int i = 1; i <= 16; i++) begin pulse(DS'(i + 100), 1); step(19); end
    pulse(24'd200, 1); step(16);
    m.m_ready = 1; step(1); m.m_ready = 0; step(5);
    m.m_ready = 1; step(20); m.m_ready = 0;
    do_reset();
    rnd = 1;
    pulse('0, 1); step(4); pulse('0, 1); step(30);
    m.m_ready = 1; step(3); m.m_ready = 0;
    do_reset();
    pulse('0, 2); step(8);
    reset = 0; sample_trig = 1; step(2);
    reset = 1; step(5);
    sample_trig = 0; step(25);
    pulse('0, 1); step(25);
    m.m_ready = 1; step(3); m.m_ready = 0;
    do_reset();
    tog = 1;
    for (int i = 0; i < 40; i++) begin pulse('0, 1); step(17 + int'($urandom_range(0, 4))); end
    tog = 0; m.m_ready = 1; step(20);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      sample_trig = ($urandom_range(0, 9) == 0) ? ~sample_trig : sample_trig;
      m.m_ready = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 999) == 0) reset = 0;
      step(1);
      reset = 1;
    end
    m.m_ready = 1; sample_trig = 0; step(40);
    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
